// File: rtl/pipo_arb_pkg.sv
// rtl/pipo_arb_pkg.sv - shared types and constants for the PIPO load arbiter
package pipo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_N    = 4;
    localparam int DEF_W    = 4;
    localparam int DEF_HOLD = 2;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting the scan at ptr
module rr_pick
    import pipo_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = idx_width(DEF_N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    logic [IW-1:0] k;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        k      = '0;
        for (int off = 0; off < N; off++) begin
            k = IW'((int'(ptr) + off) % N);
            if (!found && elig[k]) begin
                found     = 1'b1;
                idx       = k;
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipo_load_arbiter.sv
// rtl/pipo_load_arbiter.sv - round-robin load sequencer for a shared PIPO register
module pipo_load_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int W    = DEF_W,
    parameter int HOLD = DEF_HOLD
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               req,
    input  logic [N*W-1:0]             din,
    output logic [N-1:0]               ack,
    output logic [W-1:0]               po,
    output logic                       po_valid,
    output logic [idx_width(N)-1:0]    src,
    output logic                       busy
);

    localparam int IW = idx_width(N);
    localparam logic [3:0] HOLD_INIT = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;

    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic [IW-1:0] ptr, ptr_next;
    logic [N-1:0]  elig;
    logic          found;
    logic [IW-1:0] pick_idx;
    logic [N-1:0]  pick_oh;
    logic          load;
    logic [W-1:0]  word;

    // A requester being acknowledged right now must not win again this cycle.
    assign elig = req & ~ack;
    assign busy = (state == pipo_arb_pkg::HOLD);

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .elig   (elig),
        .ptr    (ptr),
        .found  (found),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ptr_next   = ptr;
        load       = 1'b0;
        word       = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_oh[i]) word = din[i*W +: W];
        end
        if (state == pipo_arb_pkg::IDLE) begin
            if (found) begin
                load     = 1'b1;
                ptr_next = (int'(pick_idx) == N - 1) ? '0 : pick_idx + IW'(1);
                if (HOLD > 0) begin
                    state_next = pipo_arb_pkg::HOLD;
                    cnt_next   = HOLD_INIT;
                end
            end
        end else begin
            if (cnt == 4'd0) state_next = pipo_arb_pkg::IDLE;
            else             cnt_next   = cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= pipo_arb_pkg::IDLE;
            cnt      <= 4'd0;
            ptr      <= '0;
            ack      <= '0;
            po       <= '0;
            po_valid <= 1'b0;
            src      <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ptr   <= ptr_next;
            ack   <= load ? pick_oh : '0;
            if (load) begin
                po       <= word;
                src      <= pick_idx;
                po_valid <= 1'b1;
            end
        end
    end

endmodule
